// File: rtl/ad9958_spi_arbiter.sv
// Two-requester arbiter in front of the AD9958 SPI serializer.
// Define AD9958_ARB_RR_EN for round-robin; default is fixed priority to req0.
module ad9958_spi_arbiter #(
    parameter int DATA_W        = 64,
    parameter int PACK_W        = 5,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_trigger,
    input  logic [PACK_W-1:0] req0_packs,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_lock,
    output logic              req0_busy,
    input  logic              req1_trigger,
    input  logic [PACK_W-1:0] req1_packs,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_lock,
    output logic              req1_busy,
    output logic              spi_trigger,
    output logic [PACK_W-1:0] spi_packs,
    output logic [DATA_W-1:0] spi_data,
    input  logic              spi_busy,
    output logic [1:0]        owner,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        pend_q, pend_d;
    logic [PACK_W-1:0] slot_packs_q [2];
    logic [PACK_W-1:0] slot_packs_d [2];
    logic [DATA_W-1:0] slot_data_q [2];
    logic [DATA_W-1:0] slot_data_d [2];
    logic              spi_trig_q, spi_trig_d;
    logic [PACK_W-1:0] spi_packs_q, spi_packs_d;
    logic [DATA_W-1:0] spi_data_q, spi_data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef AD9958_ARB_RR_EN
    logic              rr_q, rr_d;
`endif

    logic [1:0]        trig;
    logic [1:0]        lock;
    logic [PACK_W-1:0] in_packs [2];
    logic [DATA_W-1:0] in_data [2];
    logic              owner_locked;
    logic [1:0]        elig;
    logic [1:0]        pick;
    logic              done;
    logic [1:0]        busy_c;
    logic [1:0]        accept;

    assign trig        = {req1_trigger, req0_trigger};
    assign lock        = {req1_lock, req0_lock};
    assign in_packs[0] = req0_packs;
    assign in_packs[1] = req1_packs;
    assign in_data[0]  = req0_data;
    assign in_data[1]  = req1_data;

    // A locked owner shuts the other requester out of arbitration.
    always_comb begin
        owner_locked = |(owner_q & lock);
        elig         = owner_locked ? (pend_q & owner_q) : pend_q;
`ifdef AD9958_ARB_RR_EN
        if (elig == 2'b11) begin
            pick = rr_q ? 2'b10 : 2'b01;
        end else begin
            pick = elig;
        end
`else
        pick = elig[0] ? 2'b01 : elig;
`endif
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pend_d      = pend_q;
        slot_packs_d = slot_packs_q;
        slot_data_d = slot_data_q;
        spi_trig_d  = 1'b0;
        spi_packs_d = spi_packs_q;
        spi_data_d  = spi_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
`ifdef AD9958_ARB_RR_EN
        rr_d        = rr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (|pick) begin
                    owner_d     = pick;
                    state_d     = ISSUE;
                    spi_trig_d  = 1'b1;
                    spi_packs_d = pick[1] ? slot_packs_q[1] : slot_packs_q[0];
                    spi_data_d  = pick[1] ? slot_data_q[1] : slot_data_q[0];
`ifdef AD9958_ARB_RR_EN
                    rr_d        = pick[0];
`endif
                end else if (!owner_locked) begin
                    owner_d = 2'b00;
                end
            end
            ISSUE: begin
                state_d = WAIT_START;
                cnt_d   = '0;
            end
            WAIT_START: begin
                if (spi_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    done  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            pend_d  = pend_q & ~owner_q;
            if (!owner_locked) begin
                owner_d = 2'b00;
            end
        end

        // Busy drops in the completion cycle so a requester can re-arm at once.
        busy_c = pend_q & ~(done ? owner_q : 2'b00);
        accept = trig & ~busy_c;
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                pend_d[i]       = 1'b1;
                slot_packs_d[i] = in_packs[i];
                slot_data_d[i]  = in_data[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'b00;
            pend_q      <= 2'b00;
            spi_trig_q  <= 1'b0;
            spi_packs_q <= '0;
            spi_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_packs_q[i] <= '0;
                slot_data_q[i]  <= '0;
            end
`ifdef AD9958_ARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            spi_trig_q  <= spi_trig_d;
            spi_packs_q <= spi_packs_d;
            spi_data_q  <= spi_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            slot_packs_q <= slot_packs_d;
            slot_data_q <= slot_data_d;
`ifdef AD9958_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign req0_busy   = busy_c[0];
    assign req1_busy   = busy_c[1];
    assign spi_trigger = spi_trig_q;
    assign spi_packs   = spi_packs_q;
    assign spi_data    = spi_data_q;
    assign owner       = owner_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ad9958_spi_arbiter.sv
// Scoreboard bench for ad9958_spi_arbiter with a simple serializer model.
// Builds with or without AD9958_ARB_RR_EN.
module tb_ad9958_spi_arbiter;

    localparam int DW = 64;
    localparam int PW = 5;
    localparam int TO = 15;

    typedef struct packed {
        logic [1:0]    own;
        logic [PW-1:0] packs;
        logic [DW-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0_trigger, req0_lock, req0_busy;
    logic [PW-1:0] req0_packs;
    logic [DW-1:0] req0_data;
    logic          req1_trigger, req1_lock, req1_busy;
    logic [PW-1:0] req1_packs;
    logic [DW-1:0] req1_data;
    logic          spi_trigger, spi_busy, err_timeout;
    logic [PW-1:0] spi_packs;
    logic [DW-1:0] spi_data;
    logic [1:0]    owner;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_trig = 0;
    int   ser_len = 8;
    bit   ser_mute = 1'b0;
    int   base;
    exp_t exp_q[$];
    exp_t e;

    always #5 clock = ~clock;

    ad9958_spi_arbiter #(
        .DATA_W(DW),
        .PACK_W(PW),
        .START_TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req0_trigger(req0_trigger),
        .req0_packs(req0_packs),
        .req0_data(req0_data),
        .req0_lock(req0_lock),
        .req0_busy(req0_busy),
        .req1_trigger(req1_trigger),
        .req1_packs(req1_packs),
        .req1_data(req1_data),
        .req1_lock(req1_lock),
        .req1_busy(req1_busy),
        .spi_trigger(spi_trigger),
        .spi_packs(spi_packs),
        .spi_data(spi_data),
        .spi_busy(spi_busy),
        .owner(owner),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!req0_busy && !req1_busy && !spi_busy) return;
        end
        chk("idle_to", {req0_busy, req1_busy, spi_busy}, 0);
    endtask

    task automatic wait_b0_low();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!req0_busy) return;
        end
        chk("b0_to", req0_busy, 0);
    endtask

    task automatic trig0(input logic [PW-1:0] p, input logic [DW-1:0] d);
        req0_trigger = 1'b1;
        req0_packs   = p;
        req0_data    = d;
    endtask

    task automatic trig1(input logic [PW-1:0] p, input logic [DW-1:0] d);
        req1_trigger = 1'b1;
        req1_packs   = p;
        req1_data    = d;
    endtask

    task automatic untrig();
        req0_trigger = 1'b0;
        req1_trigger = 1'b0;
    endtask

    // Serializer: busy one cycle after the trigger, for ser_len cycles.
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (spi_trigger && !ser_mute) begin
                @(posedge clock);
                #1 spi_busy = 1'b1;
                repeat (ser_len) @(posedge clock);
                #1 spi_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && spi_trigger) begin
                n_trig++;
                chk("sb_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_owner", owner, e.own);
                    chk("sb_packs", spi_packs, e.packs);
                    chk("sb_data", spi_data, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req0_lock = 1'b0;
        req1_lock = 1'b0;
        req0_packs = '0;
        req0_data = '0;
        req1_packs = '0;
        req1_data = '0;
        untrig();
        tick(2);
        @(negedge clock);
        chk("rst_trig", spi_trigger, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", {req0_busy, req1_busy}, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_data", spi_data, 0);
        chk("rst_packs", spi_packs, 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Single request latency and completion
        trig0(5'd2, 64'h03);
        exp_q.push_back('{2'b01, 5'd2, 64'h03});
        @(negedge clock);
        chk("lat_b0_t0", req0_busy, 0);
        tick(1);
        untrig();
        @(negedge clock);
        chk("lat_b0_t1", req0_busy, 1);
        chk("lat_trig_t1", spi_trigger, 0);
        tick(1);
        @(negedge clock);
        chk("lat_trig_t2", spi_trigger, 1);
        tick(8);
        @(negedge clock);
        chk("lat_b0_hold", req0_busy, 1);
        tick(1);
        @(negedge clock);
        chk("lat_spi_fall", spi_busy, 0);
        chk("lat_b0_fall", req0_busy, 0);
        chk("lat_data_hold", spi_data, 64'h03);
        wait_idle();
        tick(1);

`ifdef AD9958_ARB_RR_EN
        for (int r = 0; r < 2; r++) begin
            trig0(5'd1, 64'hA);
            trig1(5'd1, 64'hB);
            exp_q.push_back('{2'b01, 5'd1, 64'hA});
            exp_q.push_back('{2'b10, 5'd1, 64'hB});
            tick(1);
            untrig();
            tick(1);
            wait_idle();
            tick(1);
        end
`else
        trig0(5'd1, 64'hA);
        trig1(5'd1, 64'hB);
        exp_q.push_back('{2'b01, 5'd1, 64'hA});
        tick(1);
        untrig();
        for (int r = 0; r < 3; r++) begin
            wait_b0_low();
            chk("fp_r1_wait", req1_busy, 1);
            trig0(5'd1, 64'hA);
            exp_q.push_back('{2'b01, 5'd1, 64'hA});
            tick(1);
            untrig();
        end
        exp_q.push_back('{2'b10, 5'd1, 64'hB});
        tick(1);
        wait_idle();
        tick(1);
`endif

        // Lock keeps req1 out between req0 transfers
        req0_lock = 1'b1;
        tick(1);
        trig0(5'd1, 64'h04);
        exp_q.push_back('{2'b01, 5'd1, 64'h04});
        tick(1);
        untrig();
        tick(2);
        trig1(5'd3, 64'h55);
        tick(1);
        untrig();
        wait_b0_low();
        tick(3);
        @(negedge clock);
        chk("lk_own1", owner, 2'b01);
        chk("lk_r1_pend1", req1_busy, 1);
        tick(1);
        trig0(5'd4, 64'h12345678);
        exp_q.push_back('{2'b01, 5'd4, 64'h12345678});
        tick(1);
        untrig();
        tick(1);
        wait_b0_low();
        tick(3);
        @(negedge clock);
        chk("lk_own2", owner, 2'b01);
        chk("lk_r1_pend2", req1_busy, 1);
        exp_q.push_back('{2'b10, 5'd3, 64'h55});
        tick(1);
        req0_lock = 1'b0;
        tick(2);
        wait_idle();
        tick(2);
        @(negedge clock);
        chk("lk_rel_own", owner, 0);
        tick(1);

        // Start timeout
        ser_mute = 1'b1;
        trig0(5'd1, 64'h21);
        exp_q.push_back('{2'b01, 5'd1, 64'h21});
        tick(1);
        untrig();
        tick(1);
        @(negedge clock);
        chk("to_trig", spi_trigger, 1);
        tick(TO - 1);
        @(negedge clock);
        chk("to_b0_wait", req0_busy, 1);
        tick(1);
        @(negedge clock);
        chk("to_err_early", err_timeout, 0);
        tick(1);
        @(negedge clock);
        chk("to_err", err_timeout, 1);
        chk("to_b0", req0_busy, 0);
        ser_mute = 1'b0;
        tick(1);
        trig1(5'd2, 64'h77);
        exp_q.push_back('{2'b10, 5'd2, 64'h77});
        tick(1);
        untrig();
        tick(1);
        wait_idle();
        chk("to_sticky", err_timeout, 1);
        tick(1);

        // Reset in the middle of a transfer
        ser_len = 20;
        trig0(5'd7, 64'h99);
        exp_q.push_back('{2'b01, 5'd7, 64'h99});
        tick(1);
        untrig();
        tick(6);
        @(negedge clock);
        chk("rm_pre_own", owner, 2'b01);
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("rm_trig", spi_trigger, 0);
        chk("rm_owner", owner, 0);
        chk("rm_busy", {req0_busy, req1_busy}, 0);
        chk("rm_err", err_timeout, 0);
        chk("rm_data", spi_data, 0);
        tick(2);
        reset_n = 1'b1;
        base = n_trig;
        tick(40);
        chk("rm_no_trig", n_trig, base);
        ser_len = 8;
        wait_idle();
        tick(1);
        trig0(5'd1, 64'hAB);
        exp_q.push_back('{2'b01, 5'd1, 64'hAB});
        tick(1);
        untrig();
        tick(1);
        wait_idle();
        tick(1);

        // Retrigger while busy is ignored
        base = n_trig;
        trig1(5'd5, 64'h111);
        exp_q.push_back('{2'b10, 5'd5, 64'h111});
        tick(1);
        untrig();
        tick(2);
        trig1(5'd6, 64'h222);
        tick(1);
        untrig();
        tick(1);
        wait_idle();
        tick(3);
        chk("rt_one_trig", n_trig - base, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
